tabela_sweeper: RTL

Sequencing controller for the 3-input combinational truth-table blocks (`tabela` family). On a start request it drives the eight input combinations a,b,c = 000…111 into the function under test. It waits a programmable settle time per vector and captures the function output `s` into an 8-bit truth vector. It then compares that vector against a parameterised expected table and reports pass/fail, a per-row mismatch mask and an error count, so a truth table is checked in hardware instead of read off a `$monitor` dump.

---
 rtl/tabela_sweeper.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tabela_sweeper.sv
// Sweeps a,b,c through rows 000..111 of a 3-input function, captures s per row and checks it against EXPECTED.
// Optional feature: define TABELA_SWEEP_ABORT_EN to add an abort input that cancels a running sweep.
module tabela_sweeper #(
  parameter logic [7:0]  EXPECTED = 8'b1001_0110,
  parameter int unsigned SETTLE   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef TABELA_SWEEP_ABORT_EN
  input  logic       abort,
`endif
  input  logic       s,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [7:0] mismatch,
  output logic [3:0] err_count
);

  // A settle time of 0 is treated as 1.
  localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
  localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       abc_q, abc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       captured_q, captured_d;
  logic [7:0]       mismatch_q, mismatch_d;
  logic [3:0]       err_q, err_d;
  logic             abort_hit;

`ifdef TABELA_SWEEP_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + 4'(v[i]);
    end
    return sum;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    abc_d      = abc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    captured_d = captured_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          idx_d      = 3'd0;
          abc_d      = 3'd0;
          cnt_d      = '0;
          captured_d = 8'd0;
          mismatch_d = 8'd0;
          err_d      = 4'd0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort_hit) begin
          state_d = ST_IDLE;
          abc_d   = 3'd0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (abort_hit) begin
          state_d = ST_IDLE;
          abc_d   = 3'd0;
          busy_d  = 1'b0;
        end else begin
          captured_d[idx_q] = s;
          if (idx_q == 3'd7) begin
            // Verdict is formed from the fully captured table on entry to DONE.
            state_d    = ST_DONE;
            done_d     = 1'b1;
            mismatch_d = captured_d ^ EXPECTED;
            err_d      = popcount8(captured_d ^ EXPECTED);
            pass_d     = (captured_d == EXPECTED);
          end else begin
            state_d = ST_SETTLE;
            idx_d   = idx_q + 3'd1;
            abc_d   = idx_q + 3'd1;
            cnt_d   = '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      abc_q      <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      captured_q <= 8'd0;
      mismatch_q <= 8'd0;
      err_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      abc_q      <= abc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      captured_q <= captured_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign a         = abc_q[2];
  assign b         = abc_q[1];
  assign c         = abc_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign captured  = captured_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;

endmodule
